// File: rtl/bus_arbiter_n_if.sv
// rtl/bus_arbiter_n_if.sv - client and server channel bundle for bus_arbiter_n
interface bus_arbiter_n_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int NR_OF_CLIENTS = 4
);
    logic [NR_OF_CLIENTS-1:0]            client_rq;
    logic [NR_OF_CLIENTS*ADDR_WIDTH-1:0] client_address;
    logic [NR_OF_CLIENTS-1:0]            client_wr_ni;
    logic [NR_OF_CLIENTS*DATA_WIDTH-1:0] client_dataW;
    logic [NR_OF_CLIENTS-1:0]            client_ack;
    logic [NR_OF_CLIENTS-1:0]            client_err;
    logic [NR_OF_CLIENTS*DATA_WIDTH-1:0] client_dataR;
    logic                                server_rq;
    logic [ADDR_WIDTH-1:0]               server_address;
    logic                                server_wr_ni;
    logic [DATA_WIDTH-1:0]               server_dataW;
    logic                                server_ack;
    logic [DATA_WIDTH-1:0]               server_dataR;

    // slave is the arbiter's view; master is the surrounding clients and server
    modport slave (
        input  client_rq, client_address, client_wr_ni, client_dataW,
        input  server_ack, server_dataR,
        output client_ack, client_err, client_dataR,
        output server_rq, server_address, server_wr_ni, server_dataW
    );

    modport master (
        output client_rq, client_address, client_wr_ni, client_dataW,
        output server_ack, server_dataR,
        input  client_ack, client_err, client_dataR,
        input  server_rq, server_address, server_wr_ni, server_dataW
    );
endinterface

// File: rtl/bus_arbiter_n.sv
// rtl/bus_arbiter_n.sv - N-client arbiter onto one server port, round-robin or aged strict priority
module bus_arbiter_n #(
    parameter int                         DATA_WIDTH      = 8,
    parameter int                         ADDR_WIDTH      = 4,
    parameter int                         NR_OF_CLIENTS   = 4,
    parameter logic [4*NR_OF_CLIENTS-1:0] CLIENT_PRIORITY = 'h0321,
    parameter int                         SCHED_MODE      = 1,
    parameter int                         AGING_LIMIT     = 8,
    parameter int                         ACK_TIMEOUT     = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    bus_arbiter_n_if.slave                   bus,
    output logic [$clog2(NR_OF_CLIENTS)-1:0] grant_id,
    output logic                             busy
);
    localparam int N  = NR_OF_CLIENTS;
    localparam int GW = $clog2(N);
    localparam int AW = (AGING_LIMIT > 0) ? $clog2(AGING_LIMIT + 1) : 1;
    localparam int TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t                  state, state_next;
    logic [GW-1:0]           last;
    logic [GW-1:0]           winner;
    logic [GW-1:0]           rr_idx;
    logic                    found;
    logic                    aged;
    logic [3:0]              best_prio;
    logic [AW-1:0]           aging [N];
    logic [TW-1:0]           tmo_cnt;
    logic                    err_q;
    logic                    timeout_hit;
    logic                    any_rq;
    logic [N*DATA_WIDTH-1:0] data_r;
    logic [N-1:0]            gnt_onehot;

    assign any_rq           = |bus.client_rq;
    assign timeout_hit      = (ACK_TIMEOUT != 0) && (tmo_cnt == TW'(ACK_TIMEOUT - 1));
    assign gnt_onehot       = {{(N-1){1'b0}}, 1'b1} << grant_id;
    assign bus.client_dataR = data_r;
    assign busy             = (state != IDLE);

    // Winner selection; only consumed while IDLE
    always_comb begin
        winner    = '0;
        rr_idx    = '0;
        found     = 1'b0;
        aged      = 1'b0;
        best_prio = '0;
        if (SCHED_MODE == 1) begin
            for (int k = 1; k <= N; k++) begin
                rr_idx = GW'((int'(last) + k) % N);
                if (!found && bus.client_rq[rr_idx]) begin
                    found  = 1'b1;
                    winner = rr_idx;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (bus.client_rq[i] && (!found || CLIENT_PRIORITY[4*i +: 4] > best_prio)) begin
                    found     = 1'b1;
                    best_prio = CLIENT_PRIORITY[4*i +: 4];
                    winner    = GW'(i);
                end
            end
            // A starved client beats any priority; lowest aged index first
            if (AGING_LIMIT != 0) begin
                for (int i = 0; i < N; i++) begin
                    if (!aged && bus.client_rq[i] && aging[i] == AW'(AGING_LIMIT)) begin
                        aged   = 1'b1;
                        winner = GW'(i);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next         = state;
        bus.server_rq      = 1'b0;
        bus.server_address = '0;
        bus.server_wr_ni   = 1'b0;
        bus.server_dataW   = '0;
        bus.client_ack     = '0;
        bus.client_err     = '0;
        case (state)
            IDLE: begin
                if (any_rq) begin
                    state_next = XFER;
                end
            end
            XFER: begin
                bus.server_rq      = 1'b1;
                bus.server_address = bus.client_address[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
                bus.server_wr_ni   = bus.client_wr_ni[grant_id];
                bus.server_dataW   = bus.client_dataW[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
                if (bus.server_ack || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.client_ack = gnt_onehot;
                bus.client_err = err_q ? gnt_onehot : '0;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_id <= '0;
            last     <= GW'(N - 1);
            tmo_cnt  <= '0;
            err_q    <= 1'b0;
            data_r   <= '0;
            for (int i = 0; i < N; i++) begin
                aging[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (any_rq) begin
                        grant_id <= winner;
                        last     <= winner;
                        tmo_cnt  <= '0;
                        err_q    <= 1'b0;
                        for (int i = 0; i < N; i++) begin
                            if (SCHED_MODE == 0 && AGING_LIMIT != 0 &&
                                bus.client_rq[i] && GW'(i) != winner) begin
                                if (aging[i] != AW'(AGING_LIMIT)) begin
                                    aging[i] <= aging[i] + 1'b1;
                                end
                            end else begin
                                aging[i] <= '0;
                            end
                        end
                    end
                end
                XFER: begin
                    if (bus.server_ack) begin
                        if (!bus.client_wr_ni[grant_id]) begin
                            data_r[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH] <= bus.server_dataR;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (timeout_hit) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter_n.sv
// tb/tb_bus_arbiter_n.sv - scoreboard bench for bus_arbiter_n in round-robin and strict/aging modes
module tb_bus_arbiter_n;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int N  = 4;

    typedef struct {
        int         id;
        bit         err;
        bit         rd;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  rq     [2];
    logic [3:0]  hold   [2];
    logic        srv_on [2];
    logic        srv_ack[2];
    logic [7:0]  srv_rd [2];
    logic [15:0] addr;
    logic [3:0]  wr;
    logic [31:0] dw;

    logic [3:0]  ack_o [2];
    logic [3:0]  err_o [2];
    logic [31:0] dr_o  [2];
    logic        srq_o [2];
    logic [3:0]  sad_o [2];
    logic        swr_o [2];
    logic [7:0]  sdw_o [2];
    logic [1:0]  gid   [2];
    logic        bsy   [2];
    logic [1:0]  gid_rr, gid_sp;
    logic        busy_rr, busy_sp;

    logic [7:0]  mem [2][16];
    logic [7:0]  mdr [2][4];
    exp_t        q0[$];
    exp_t        q1[$];
    int          errors = 0;
    int          checks = 0;

    bus_arbiter_n_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NR_OF_CLIENTS(N)) if_rr ();
    bus_arbiter_n_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NR_OF_CLIENTS(N)) if_sp ();

    bus_arbiter_n #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NR_OF_CLIENTS(N),
                    .SCHED_MODE(1), .AGING_LIMIT(8), .ACK_TIMEOUT(16)) dut_rr (
        .clk(clk), .reset(rst_n), .bus(if_rr), .grant_id(gid_rr), .busy(busy_rr));

    bus_arbiter_n #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NR_OF_CLIENTS(N),
                    .SCHED_MODE(0), .AGING_LIMIT(2), .ACK_TIMEOUT(16)) dut_sp (
        .clk(clk), .reset(rst_n), .bus(if_sp), .grant_id(gid_sp), .busy(busy_sp));

    assign if_rr.client_rq      = rq[0];
    assign if_rr.client_address = addr;
    assign if_rr.client_wr_ni   = wr;
    assign if_rr.client_dataW   = dw;
    assign if_rr.server_ack     = srv_ack[0];
    assign if_rr.server_dataR   = srv_rd[0];
    assign if_sp.client_rq      = rq[1];
    assign if_sp.client_address = addr;
    assign if_sp.client_wr_ni   = wr;
    assign if_sp.client_dataW   = dw;
    assign if_sp.server_ack     = srv_ack[1];
    assign if_sp.server_dataR   = srv_rd[1];

    assign ack_o[0] = if_rr.client_ack;     assign ack_o[1] = if_sp.client_ack;
    assign err_o[0] = if_rr.client_err;     assign err_o[1] = if_sp.client_err;
    assign dr_o[0]  = if_rr.client_dataR;   assign dr_o[1]  = if_sp.client_dataR;
    assign srq_o[0] = if_rr.server_rq;      assign srq_o[1] = if_sp.server_rq;
    assign sad_o[0] = if_rr.server_address; assign sad_o[1] = if_sp.server_address;
    assign swr_o[0] = if_rr.server_wr_ni;   assign swr_o[1] = if_sp.server_wr_ni;
    assign sdw_o[0] = if_rr.server_dataW;   assign sdw_o[1] = if_sp.server_dataW;
    assign gid[0]   = gid_rr;               assign gid[1]   = gid_sp;
    assign bsy[0]   = busy_rr;              assign bsy[1]   = busy_sp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sb_size(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push(input int d, input int id, input bit err, input bit rd, input logic [7:0] data);
        exp_t e;
        e.id = id; e.err = err; e.rd = rd; e.data = data;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // One clock: score any completion, apply client drop, then act as the server
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (ack_o[d] != 4'b0) begin
                if (sb_size(d) == 0) begin
                    chk("unexpected_ack", {28'b0, ack_o[d]}, 32'h0);
                end else begin
                    if (d == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk("ack_vec", {28'b0, ack_o[d]}, 32'h1 << e.id);
                    chk("err_vec", {28'b0, err_o[d]}, e.err ? (32'h1 << e.id) : 32'h0);
                    chk("grant_id", {30'b0, gid[d]}, e.id);
                    if (e.rd && !e.err) mdr[d][e.id] = e.data;
                    chk("dataR", {24'b0, dr_o[d][e.id*8 +: 8]}, {24'b0, mdr[d][e.id]});
                end
                rq[d] = rq[d] & ~(ack_o[d] & ~hold[d]);
            end
            if (srq_o[d] && srv_on[d]) begin
                srv_ack[d] = 1'b1;
                if (swr_o[d]) mem[d][sad_o[d]] = sdw_o[d];
                else          srv_rd[d] = mem[d][sad_o[d]];
            end else begin
                srv_ack[d] = 1'b0;
            end
        end
    endtask

    task automatic drain(input int d, input int budget, output int n);
        n = 0;
        while (sb_size(d) != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_bound", sb_size(d), 0);
        rq[d]   = '0;
        hold[d] = '0;
    endtask

    task automatic chk_zero(input int d);
        chk("z_ack",  {28'b0, ack_o[d]}, 32'h0);
        chk("z_err",  {28'b0, err_o[d]}, 32'h0);
        chk("z_dr",   dr_o[d], 32'h0);
        chk("z_srq",  {31'b0, srq_o[d]}, 32'h0);
        chk("z_sad",  {28'b0, sad_o[d]}, 32'h0);
        chk("z_swr",  {31'b0, swr_o[d]}, 32'h0);
        chk("z_sdw",  {24'b0, sdw_o[d]}, 32'h0);
        chk("z_gid",  {30'b0, gid[d]}, 32'h0);
        chk("z_busy", {31'b0, bsy[d]}, 32'h0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        addr  = {4'd7, 4'd6, 4'd5, 4'd4};
        wr    = 4'b0000;
        dw    = '0;
        for (int d = 0; d < 2; d++) begin
            rq[d] = '0; hold[d] = '0; srv_on[d] = 1'b1; srv_ack[d] = 1'b0; srv_rd[d] = '0;
            for (int a = 0; a < 16; a++) mem[d][a] = 8'(8'h11 * a);
            for (int c = 0; c < 4; c++) mdr[d][c] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk_zero(0);
        chk_zero(1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Round robin from reset: 0,1,2,3,0 with one transfer per 3 cycles
        push(0, 0, 0, 1, 8'h44); push(0, 1, 0, 1, 8'h55); push(0, 2, 0, 1, 8'h66);
        push(0, 3, 0, 1, 8'h77); push(0, 0, 0, 1, 8'h44);
        hold[0] = 4'hF;
        rq[0]   = 4'hF;
        drain(0, 40, n);
        chk("rr_cycles", n, 14);
        tick();

        // Single write by client 2, then read it back
        addr[8 +: 4] = 4'd9;
        wr[2]        = 1'b1;
        dw[16 +: 8]  = 8'hA5;
        push(0, 2, 0, 0, 8'h00);
        rq[0][2] = 1'b1;
        chk("pre_srq", {31'b0, srq_o[0]}, 32'h0);
        tick();
        chk("wr_srq",  {31'b0, srq_o[0]}, 32'h1);
        chk("wr_addr", {28'b0, sad_o[0]}, 32'h9);
        chk("wr_data", {24'b0, sdw_o[0]}, 32'hA5);
        chk("wr_dir",  {31'b0, swr_o[0]}, 32'h1);
        chk("wr_gid",  {30'b0, gid[0]}, 32'h2);
        chk("wr_busy", {31'b0, bsy[0]}, 32'h1);
        tick();
        chk("done_srq",  {31'b0, srq_o[0]}, 32'h0);
        chk("done_busy", {31'b0, bsy[0]}, 32'h1);
        chk("done_qlen", sb_size(0), 0);
        tick();
        chk("idle_busy", {31'b0, bsy[0]}, 32'h0);
        wr[2] = 1'b0;
        push(0, 2, 0, 1, 8'hA5);
        rq[0][2] = 1'b1;
        drain(0, 20, n);
        chk("rd_cycles", n, 2);
        tick();

        // Timeout on client 1; stray acks afterwards must be ignored
        srv_on[0]    = 1'b0;
        addr[4 +: 4] = 4'd3;
        push(0, 1, 1, 1, 8'h00);
        rq[0][1] = 1'b1;
        tick();
        n = 0;
        while (srq_o[0] && n < 100) begin
            n++;
            tick();
        end
        chk("tmo_xfer_len", n, 16);
        chk("tmo_qlen", sb_size(0), 0);
        srv_ack[0] = 1'b1;
        tick();
        srv_ack[0] = 1'b1;
        tick();
        chk("stray_ack",  {28'b0, ack_o[0]}, 32'h0);
        chk("stray_busy", {31'b0, bsy[0]}, 32'h0);
        chk("stray_dr1",  {24'b0, dr_o[0][8 +: 8]}, 32'h55);
        tick();
        chk("stray_ack2", {28'b0, ack_o[0]}, 32'h0);

        // Strict priority: 2 (prio 3), then 1, then 0
        addr = {4'd7, 4'd6, 4'd5, 4'd4};
        push(1, 2, 0, 1, 8'h66); push(1, 1, 0, 1, 8'h55); push(1, 0, 0, 1, 8'h44);
        rq[1] = 4'b0111;
        drain(1, 40, n);
        tick();

        // Aging limit 2: client 0 wins its third arbitration against a persistent client 2
        push(1, 2, 0, 1, 8'h66); push(1, 2, 0, 1, 8'h66); push(1, 0, 0, 1, 8'h44);
        hold[1] = 4'b0100;
        rq[1]   = 4'b0101;
        drain(1, 40, n);
        tick();

        // Reset in the middle of a transfer abandons it
        hold[0] = 4'hF;
        rq[0]   = 4'hF;
        tick();
        chk("mid_srq", {31'b0, srq_o[0]}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk_zero(0);
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 4; c++) mdr[d][c] = '0;
        tick();
        chk("rst_hold_ack", {28'b0, ack_o[0]}, 32'h0);
        @(negedge clk);
        srv_on[0] = 1'b1;
        push(0, 0, 0, 1, 8'h44);
        rst_n = 1'b1;
        drain(0, 20, n);
        chk("post_rst_cycles", n, 2);
        tick();
        chk("end_busy", {31'b0, bsy[0]}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bus_arbiter_n.md
# bus_arbiter_n

Parametrised N-client bus arbiter that multiplexes client request/acknowledge transactions onto a single server port (typically the `ram` memory model). It generalises the fixed four-client arbiter to `NR_OF_CLIENTS` packed channels and supports strict-priority (with anti-starvation aging) and round-robin scheduling. It also adds a server-acknowledge timeout that completes a stalled transfer with an error flag. It sits between the client instances and the server in the system testbench and in any multi-master memory subsystem.

## Interface

- `DATA_WIDTH`, 8, data bus width.
- `ADDR_WIDTH`, 4, address bus width.
- `NR_OF_CLIENTS`, 4, number of client channels, 2..16.
- `CLIENT_PRIORITY`, 16'h0321, packed 4 bits per client (client i at [4i+3:4i]); higher value wins, ties go to the lower index.
- `SCHED_MODE`, 1, 0 = strict priority, 1 = round robin.
- `AGING_LIMIT`, 8, strict mode only: consecutive lost arbitrations before forced grant; 0 disables aging.
- `ACK_TIMEOUT`, 16, XFER cycles without `server_ack` before error completion; 0 disables the timeout.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `client_rq`  in  N  per-client request, held until acknowledged.
- `client_address`  in  N*ADDR_WIDTH  packed addresses.
- `client_wr_ni`  in  N  1 = write, 0 = read.
- `client_dataW`  in  N*DATA_WIDTH  packed write data.
- `client_ack`  out  N  one-cycle completion pulse to the granted client.
- `client_err`  out  N  high together with `client_ack` on a timeout completion.
- `client_dataR`  out  N*DATA_WIDTH  per-client registered read data.
- `server_rq`  out  1  request to the server.
- `server_address`  out  ADDR_WIDTH  muxed address.
- `server_wr_ni`  out  1  muxed direction.
- `server_dataW`  out  DATA_WIDTH  muxed write data.
- `server_ack`  in  1  server completion.
- `server_dataR`  in  DATA_WIDTH  server read data.
- `grant_id`  out  $clog2(N)  index of the current or last granted client.
- `busy`  out  1  high in XFER and DONE.

## Operation

- FSM states: IDLE, XFER, DONE.
- **IDLE**
  - If any `client_rq` bit is high, select a winner, register it in `grant_id`, and move to XFER.
  - Otherwise stay in IDLE.
- **XFER**
  - `server_rq`=1.
  - `server_address`, `server_wr_ni` and `server_dataW` carry the inputs of client `grant_id`, sampled live.
  - On `server_ack`: capture `server_dataR` into the `client_dataR` slice of the granted client (reads only; writes leave it unchanged), then go to DONE.
  - If the timeout counter reaches `ACK_TIMEOUT` with no ack: go to DONE with the error flag set and do not touch `client_dataR`.
- **DONE**
  - `server_rq`=0.
  - `client_ack[grant_id]`=1 for exactly this cycle; `client_err[grant_id]`=1 only on timeout.
  - Next state is always IDLE.
- Client contract: drop `rq` on the edge after seeing `ack`. The IDLE cycle after DONE therefore no longer sees the old request.
- **Round robin**
  - Pointer `last` holds the last winner; search starts at `last`+1 and wraps modulo N.
  - Reset value of `last` is N-1, so client 0 is served first.
- **Strict priority**
  - Highest `CLIENT_PRIORITY` value wins; ties go to the lower index.
- **Aging (strict mode only)**
  - Each client has a saturating counter.
  - In an IDLE arbitration, a requesting loser increments; the winner and non-requesting clients clear.
  - Any client whose counter equals `AGING_LIMIT` overrides priority; among several aged clients the lowest index wins.
- **Timeout counter**
  - Cleared on entry to XFER and incremented each XFER cycle without ack.
  - Width is $clog2(ACK_TIMEOUT+1).
- A `server_ack` seen in IDLE or DONE (late ack after a timeout) is ignored.

## Timing

- Reset (async assert, sync release) gives:
  - FSM in IDLE.
  - All outputs 0: `client_ack`, `client_err`, `client_dataR`, `server_*`, `grant_id`, `busy`.
  - Aging and timeout counters 0; `last`=N-1.
- Reset asserted mid-XFER: `server_rq` drops immediately and the transaction is abandoned with no ack to the client.
- Request sampled in IDLE at edge k gives `server_rq` high from k+1.
- `server_ack` in cycle m gives `client_ack` in cycle m+1.
- With a zero-delay server (ack in the first XFER cycle): request to ack is 2 cycles, and peak throughput is one transfer per 3 cycles.
- Timeout: XFER lasts exactly `ACK_TIMEOUT` cycles, then the DONE cycle carries the error.
- Requests arriving during XFER or DONE wait; arbitration happens only in IDLE.
- `grant_id` is stable from the IDLE→XFER edge until the next grant.

## Test plan

- **Single request:** N=4, client 2 write addr 9 data 8'hA5 → `server_rq` with addr 9 / 8'hA5 / wr_ni=1 one cycle later; `client_ack[2]` one pulse; a read of addr 9 returns 8'hA5 on `client_dataR` slice 2.
- **Round robin:** all 4 clients request continuously → grant order 0,1,2,3,0; each client is acked once per 4 transfers.
- **Strict priority:** default priorities with clients 0, 1, 2 requesting → client 2 (prio 3) first, then 1, then 0.
- **Aging:** `AGING_LIMIT`=2, client 2 re-requests continuously, client 0 requesting → client 0 is granted on its third arbitration despite lower priority.
- **Timeout:** server never acks, `ACK_TIMEOUT`=16 → XFER lasts 16 cycles, then `client_ack[g]`=1 and `client_err[g]`=1 with `client_dataR` unchanged; a later stray ack is ignored.
- **Reset mid-transfer:** reset low during XFER → all outputs 0 immediately; after release, the first grant with all clients requesting in round-robin mode goes to client 0.
